// File: rtl/pc_pkg.sv
// Shared types for the MINI-RISC fetch-stage PC sequencer: FSM states,
// resolved per-cycle actions and the command priority resolver.
package pc_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      ACT_HOLD = 3'd0,
      ACT_INC  = 3'd1,
      ACT_BR   = 3'd2,
      ACT_REL  = 3'd3,
      ACT_CALL = 3'd4,
      ACT_RET  = 3'd5
   } act_e;

   // One action per cycle; anything lower in the chain is dropped, never queued.
   function automatic act_e resolve_action(input logic stall,
                                           input logic ret_en,
                                           input logic call_en,
                                           input logic branch_en,
                                           input logic rel_en,
                                           input logic inc);
      act_e act;
      if (stall) begin
         act = ACT_HOLD;
      end else if (ret_en) begin
         act = ACT_RET;
      end else if (call_en) begin
         act = ACT_CALL;
      end else if (branch_en) begin
         act = ACT_BR;
      end else if (rel_en) begin
         act = ACT_REL;
      end else if (inc) begin
         act = ACT_INC;
      end else begin
         act = ACT_HOLD;
      end
      return act;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry,
// a pop while empty only raises an underflow event.
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W    = 11,
   parameter int RAS_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              ovf_evt,
   output logic              unf_evt
);

   localparam int IDX_W = $clog2(RAS_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  cnt_q, cnt_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              wr_en_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [IDX_W-1:0]  top_idx_s;

   assign wr_idx_s  = ptr_q[IDX_W-1:0];
   assign top_idx_s = ptr_q[IDX_W-1:0] - IDX_W'(1);

   // Next pointer/count; pop takes precedence so a stray push+pop never pushes.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wr_en_s = 1'b0;
      if (pop) begin
         if (cnt_q != PTR_W'(0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - PTR_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else if (push) begin
         wr_en_s = 1'b1;
         ptr_d   = ptr_q + PTR_W'(1);
         if (cnt_q != PTR_W'(RAS_DEPTH)) begin
            cnt_d = cnt_q + PTR_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         wr_en_s = 1'b0;
      end
      empty_d = (cnt_d == PTR_W'(0));
      full_d  = (cnt_d == PTR_W'(RAS_DEPTH));
   end

   // Pointer, count and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   // Storage array; contents are meaningless once the count is reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_idx_s] <= din;
      end
   end

   assign top     = mem_q[top_idx_s];
   assign empty   = empty_q;
   assign full    = full_q;
   assign ovf_evt = push & ~pop & full_q;
   assign unf_evt = pop & empty_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program-counter sequencer: RUN/HALTED FSM, command priority
// decode, next-PC mux, return-address stack and sticky RAS error flags.
module pc_seq_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W     = 11,
   parameter int                OFF_W      = 8,
   parameter int                RAS_DEPTH  = 8,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              resume,
   input  logic              stall,
   input  logic              inc,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              rel_en,
   input  logic [OFF_W-1:0]  rel_off,
   input  logic              call_en,
   input  logic              ret_en,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] current_addr,
   output logic              halted,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   act_e              act_s;
   logic              push_s, pop_s;
   logic [ADDR_W-1:0] pc_inc_s;
   logic [ADDR_W-1:0] rel_ext_s;
   logic [ADDR_W-1:0] ras_top_s;
   logic              ras_empty_s, ras_full_s;
   logic              ovf_evt_s, unf_evt_s;

   assign act_s     = resolve_action(stall, ret_en, call_en, branch_en, rel_en, inc);
   assign pc_inc_s  = pc_q + ADDR_W'(1);
   assign rel_ext_s = ADDR_W'($signed(rel_off));

   pc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push    (push_s),
      .pop     (pop_s),
      .din     (pc_inc_s),
      .top     (ras_top_s),
      .empty   (ras_empty_s),
      .full    (ras_full_s),
      .ovf_evt (ovf_evt_s),
      .unf_evt (unf_evt_s)
   );

   // FSM transitions and next-PC mux; the PC holds on every state-change cycle.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_RUN;
               case (act_s)
                  ACT_INC:  pc_d = pc_inc_s;
                  ACT_BR:   pc_d = branch_addr;
                  ACT_REL:  pc_d = pc_q + rel_ext_s;
                  ACT_CALL: begin
                     push_s = 1'b1;
                     pc_d   = branch_addr;
                  end
                  ACT_RET: begin
                     pop_s = 1'b1;
                     pc_d  = ras_empty_s ? pc_inc_s : ras_top_s;
                  end
                  default:  pc_d = pc_q;
               endcase
            end
         end
         ST_HALTED: begin
            if (resume && !halt) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: state_d = ST_RUN;
      endcase
      halted_d = (state_d == ST_HALTED);
      // A set event in the same cycle beats clr_err.
      ovf_d = ovf_evt_s | (ovf_q & ~clr_err);
      unf_d = unf_evt_s | (unf_q & ~clr_err);
   end

   // Architectural state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_ADDR;
         halted_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign current_addr = pc_q;
   assign halted       = halted_q;
   assign ras_empty    = ras_empty_s;
   assign ras_full     = ras_full_s;
   assign ras_ovf      = ovf_q;
   assign ras_unf      = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_seq_unit;

   localparam int AW = 11;
   localparam int OW = 8;
   localparam int D  = 8;
   localparam int M  = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic          halt, resume, stall, inc, branch_en, rel_en, call_en, ret_en, clr_err;
   logic [AW-1:0] branch_addr;
   logic [OW-1:0] rel_off;
   logic [AW-1:0] current_addr;
   logic          halted, ras_empty, ras_full, ras_ovf, ras_unf;

   int checks = 0;
   int errors = 0;

   int m_pc;
   bit m_halted, m_ovf, m_unf;
   int m_ras[$];
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pc_seq_unit #(.ADDR_W(AW), .OFF_W(OW), .RAS_DEPTH(D), .RESET_ADDR(11'd0)) dut (
      .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stall(stall), .inc(inc),
      .branch_en(branch_en), .branch_addr(branch_addr), .rel_en(rel_en), .rel_off(rel_off),
      .call_en(call_en), .ret_en(ret_en), .clr_err(clr_err),
      .current_addr(current_addr), .halted(halted), .ras_empty(ras_empty),
      .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic clear_in();
      halt = 1'b0; resume = 1'b0; stall = 1'b0; inc = 1'b0; branch_en = 1'b0;
      rel_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; clr_err = 1'b0;
      branch_addr = '0; rel_off = '0;
   endtask

   task automatic model_reset();
      m_pc = 0; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
   endtask

   // Effect of one clock edge, straight from the command rules.
   task automatic model_step();
      bit ovf_s, unf_s;
      int sx;
      ovf_s = 1'b0; unf_s = 1'b0;
      if (m_halted) begin
         if (resume && !halt) m_halted = 1'b0;
      end else if (halt) begin
         m_halted = 1'b1;
      end else if (stall) begin
         m_pc = m_pc;
      end else if (ret_en) begin
         if (m_ras.size() > 0) m_pc = m_ras.pop_back();
         else begin m_pc = (m_pc + 1) % M; unf_s = 1'b1; end
      end else if (call_en) begin
         if (m_ras.size() == D) begin void'(m_ras.pop_front()); ovf_s = 1'b1; end
         m_ras.push_back((m_pc + 1) % M);
         m_pc = int'(branch_addr);
      end else if (branch_en) begin
         m_pc = int'(branch_addr);
      end else if (rel_en) begin
         sx = int'($signed(rel_off));
         m_pc = (((m_pc + sx) % M) + M) % M;
      end else if (inc) begin
         m_pc = (m_pc + 1) % M;
      end
      m_ovf = ovf_s | (m_ovf & !clr_err);
      m_unf = unf_s | (m_unf & !clr_err);
   endtask

   // One clock: edge, model update, settle, then drop all commands.
   task automatic cyc();
      @(posedge clk);
      if (!rst) model_step();
      #1;
      clear_in();
   endtask

   // Every-cycle comparison against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("pc", current_addr, m_pc);
         chk("halted", halted, m_halted);
         chk("ras_empty", ras_empty, m_ras.size() == 0);
         chk("ras_full", ras_full, m_ras.size() == D);
         chk("ras_ovf", ras_ovf, m_ovf);
         chk("ras_unf", ras_unf, m_unf);
      end
   end

   initial begin
      rst = 1'b1;
      clear_in();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_pc", current_addr, 0);
      chk("rst_halted", halted, 0);
      chk("rst_empty", ras_empty, 1);
      chk("rst_full", ras_full, 0);
      chk("rst_ovf", ras_ovf, 0);
      chk("rst_unf", ras_unf, 0);
      chk_en = 1'b1;

      for (int i = 1; i <= 5; i++) begin
         inc = 1'b1; cyc();
         chk("inc_seq", current_addr, i);
      end
      branch_en = 1'b1; branch_addr = 11'd2047; cyc();
      chk("br_max", current_addr, 2047);
      inc = 1'b1; cyc();
      chk("inc_wrap", current_addr, 0);

      branch_en = 1'b1; branch_addr = 11'd10; cyc();
      rel_en = 1'b1; rel_off = 8'hFD; cyc();
      chk("rel_neg", current_addr, 7);
      branch_en = 1'b1; branch_addr = 11'd0; cyc();
      rel_en = 1'b1; rel_off = 8'hFF; cyc();
      chk("rel_wrap", current_addr, 2047);

      branch_en = 1'b1; branch_addr = 11'd4; cyc();
      call_en = 1'b1; branch_addr = 11'd100; cyc();
      chk("call1_pc", current_addr, 100);
      chk("call1_empty", ras_empty, 0);
      call_en = 1'b1; branch_addr = 11'd200; cyc();
      chk("call2_pc", current_addr, 200);
      ret_en = 1'b1; cyc();
      chk("ret1_pc", current_addr, 101);
      ret_en = 1'b1; cyc();
      chk("ret2_pc", current_addr, 5);
      chk("ret2_empty", ras_empty, 1);
      ret_en = 1'b1; cyc();
      chk("ret3_pc", current_addr, 6);
      chk("ret3_unf", ras_unf, 1);
      clr_err = 1'b1; cyc();
      chk("clr_unf", ras_unf, 0);

      branch_en = 1'b1; branch_addr = 11'd300; cyc();
      for (int i = 0; i < 9; i++) begin
         call_en = 1'b1; branch_addr = 11'(400 + i); cyc();
      end
      chk("ovf_full", ras_full, 1);
      chk("ovf_flag", ras_ovf, 1);
      for (int j = 0; j < 8; j++) begin
         ret_en = 1'b1; cyc();
         chk("lifo_pc", current_addr, 408 - j);
      end
      chk("lifo_empty", ras_empty, 1);
      clr_err = 1'b1; cyc();
      chk("clr_ovf", ras_ovf, 0);

      branch_en = 1'b1; branch_addr = 11'd20; cyc();
      halt = 1'b1; cyc();
      chk("halt_on", halted, 1);
      for (int k = 0; k < 3; k++) begin
         inc = 1'b1; branch_en = 1'b1; call_en = 1'b1; branch_addr = 11'd77; cyc();
         chk("halt_hold", current_addr, 20);
      end
      chk("halt_nopush", ras_empty, 1);
      halt = 1'b1; resume = 1'b1; cyc();
      chk("halt_resume_both", halted, 1);
      resume = 1'b1; cyc();
      chk("resume_off", halted, 0);
      chk("resume_pc", current_addr, 20);
      inc = 1'b1; cyc();
      chk("resume_inc", current_addr, 21);

      stall = 1'b1; branch_en = 1'b1; branch_addr = 11'd500; inc = 1'b1; cyc();
      chk("stall_hold", current_addr, 21);

      branch_en = 1'b1; branch_addr = 11'd49; cyc();
      call_en = 1'b1; branch_addr = 11'd60; cyc();
      call_en = 1'b1; ret_en = 1'b1; branch_addr = 11'd70; cyc();
      chk("callret_pc", current_addr, 50);
      chk("callret_nopush", ras_empty, 1);

      call_en = 1'b1; branch_addr = 11'd90; cyc();
      halt = 1'b1; cyc();
      #3 rst = 1'b1;
      #1;
      chk("async_pc", current_addr, 0);
      chk("async_empty", ras_empty, 1);
      chk("async_halted", halted, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         halt        = ($urandom % 25) == 0;
         resume      = ($urandom % 3) == 0;
         stall       = ($urandom % 8) == 0;
         ret_en      = ($urandom % 4) == 0;
         call_en     = ($urandom % 4) == 0;
         branch_en   = ($urandom % 6) == 0;
         rel_en      = ($urandom % 4) == 0;
         inc         = ($urandom % 2) == 0;
         clr_err     = ($urandom % 12) == 0;
         branch_addr = AW'($urandom % M);
         rel_off     = OW'($urandom);
         cyc();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
